// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// It holds one instruction between the execute stage and the write-back stage.
// For loads it waits for the data-SRAM response. It then extracts and extends
// the loaded byte, halfword or word, including the lwl/lwr partial writes.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   es_to_ms_valid/bus   instruction offered by the execute stage (101 b)
//   ms_allowin           MS can take a new instruction this cycle
//   ws_allowin           write-back stage can accept
//   ms_to_ws_valid/bus   result handed to write-back (91 b)
//   ms_to_ds_bus         forwarding/interlock information for decode (42 b)
//   data_sram_data_ok    one-cycle response pulse, responses in request order
//   data_sram_rdata      response data, valid with data_ok
//   ws_ex, ws_eret       flush requests from write-back
//   ms_ex_eret           MS holds an excepting instruction or an eret
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 101,
    parameter int MS_TO_WS_BUS_WD = 91,
    parameter int MS_TO_DS_BUS_WD = 42
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ws_ex,
    input  logic                       ws_eret,
    output logic                       ms_ex_eret
);

    // Extract and extend the loaded value. ld_op is one-hot:
    // bit 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 lwl, 6 lwr.
    function automatic logic [31:0] load_extract(input logic [6:0]  op,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = r[{a, 3'b000} +: 8];
        h = r[{a[1], 4'b0000} +: 16];
        if (op[0])      res = {{24{b[7]}}, b};
        else if (op[1]) res = {24'd0, b};
        else if (op[2]) res = {{16{h[15]}}, h};
        else if (op[3]) res = {16'd0, h};
        else if (op[5]) res = r << {~a, 3'b000};   // 8*(3-a)
        else if (op[6]) res = r >> {a, 3'b000};    // 8*a
        else            res = r;
        return res;
    endfunction

    // Per-byte register write enables; only lwl/lwr write partial words.
    function automatic logic [3:0] load_we(input logic [6:0] op,
                                           input logic [1:0] a,
                                           input logic [3:0] we);
        logic [3:0] res;
        if (op[5])      res = 4'b1111 << ~a;
        else if (op[6]) res = 4'b1111 >> a;
        else            res = we;
        return res;
    endfunction

    logic                       ms_valid_q, ms_valid_d;
    logic                       buf_valid_q, buf_valid_d;
    logic                       drop_q, drop_d;
    logic [31:0]                buf_q;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;

    logic [10:0] root_bus;
    logic [6:0]  exc_info;       // {bd, ex, excode}
    logic [6:0]  ld_op;
    logic        req_sent;
    logic [1:0]  addr_lo;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign root_bus   = bus_q[100:90];
    assign exc_info   = bus_q[89:83];
    assign ld_op      = bus_q[82:76];
    assign req_sent   = bus_q[75];
    assign addr_lo    = bus_q[74:73];
    assign rf_we      = bus_q[72:69];
    assign dest       = bus_q[68:64];
    assign alu_result = bus_q[63:32];
    assign pc         = bus_q[31:0];

    logic        flush;
    logic        data_ready;
    logic        ms_ready_go;
    logic        load_pending;
    logic        is_load;
    logic [31:0] rdata_sel;
    logic [31:0] final_result;
    logic [3:0]  out_we;

    assign flush       = ws_ex | ws_eret;
    // A response arriving while drop is set belongs to a discarded load.
    assign data_ready  = buf_valid_q | (data_sram_data_ok & ~drop_q);
    assign ms_ready_go = ~req_sent | data_ready;
    assign load_pending = ms_valid_q & req_sent & ~data_ready;

    assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~flush;
    assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_ex_eret     = ms_valid_q & (exc_info[5] | root_bus[10]);

    // Excepting instructions have req_sent=0 and pass through unchanged.
    assign is_load      = req_sent & (|ld_op);
    assign rdata_sel    = buf_valid_q ? buf_q : data_sram_rdata;
    assign final_result = is_load ? load_extract(ld_op, addr_lo, rdata_sel) : alu_result;
    assign out_we       = is_load ? load_we(ld_op, addr_lo, rf_we) : rf_we;

    assign ms_to_ws_bus = {root_bus, exc_info, out_we, dest, final_result, pc};
    assign ms_to_ds_bus = {out_we & {4{ms_valid_q}}, load_pending, dest, final_result};

    always_comb begin
        ms_valid_d  = ms_valid_q;
        buf_valid_d = buf_valid_q;
        drop_d      = drop_q;

        if (flush)
            ms_valid_d = 1'b0;
        else if (ms_allowin)
            ms_valid_d = es_to_ms_valid;

        // Hold the response only when WS cannot take it in the same cycle.
        if (flush || (ms_to_ws_valid && ws_allowin))
            buf_valid_d = 1'b0;
        else if (data_sram_data_ok && !drop_q && ms_valid_q && req_sent &&
                 !buf_valid_q && !ws_allowin)
            buf_valid_d = 1'b1;

        // A flushed load still has its response in flight; swallow it later.
        if (flush && load_pending)
            drop_d = 1'b1;
        else if (data_sram_data_ok && drop_q)
            drop_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
            drop_q      <= drop_d;
        end
    end

    // Data registers carry no reset; their contents are qualified by the valids.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin && !flush)
            bus_q <= es_to_ms_bus;
        if (data_sram_data_ok && !drop_q && ms_valid_q && req_sent &&
            !buf_valid_q && !ws_allowin && !flush)
            buf_q <= data_sram_rdata;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

    typedef struct packed {
        logic [10:0] root;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic [6:0]  op;
        logic        req;
        logic [1:0]  a;
        logic [3:0]  we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
    } ins_t;

    localparam logic [6:0] NOP = 7'b0000000;
    localparam logic [6:0] LB  = 7'b0000001;
    localparam logic [6:0] LBU = 7'b0000010;
    localparam logic [6:0] LH  = 7'b0000100;
    localparam logic [6:0] LHU = 7'b0001000;
    localparam logic [6:0] LW  = 7'b0010000;
    localparam logic [6:0] LWL = 7'b0100000;
    localparam logic [6:0] LWR = 7'b1000000;

    logic         clk = 1'b0;
    logic         resetn;
    logic         es_to_ms_valid;
    logic [100:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [90:0]  ms_to_ws_bus;
    logic [41:0]  ms_to_ds_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_ex;
    logic         ws_eret;
    logic         ms_ex_eret;

    int vectors = 0;
    int errs    = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_ex             (ws_ex),
        .ws_eret           (ws_eret),
        .ms_ex_eret        (ms_ex_eret)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [6:0] op, input logic req, input logic [1:0] a,
                                input logic [3:0] we, input logic [4:0] dest,
                                input logic [31:0] alu, input logic ex, input logic [10:0] root);
        ins_t i;
        i        = '0;
        i.root   = root;
        i.ex     = ex;
        i.excode = ex ? 5'd4 : 5'd0;
        i.op     = op;
        i.req    = req;
        i.a      = a;
        i.we     = we;
        i.dest   = dest;
        i.alu    = alu;
        i.pc     = 32'hBFC0_0000 + {25'd0, dest, 2'b00};
        return i;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_result(input ins_t i, input logic [31:0] r);
        int          sh;
        logic [31:0] v;
        if (!i.req || i.op == NOP) return i.alu;
        sh = 8 * i.a;
        case (i.op)
            LB:      begin v = (r >> sh) & 32'hFF; if (v[7]) v = v | 32'hFFFF_FF00; end
            LBU:     v = (r >> sh) & 32'hFF;
            LH:      begin v = (r >> (16 * (i.a / 2))) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
            LHU:     v = (r >> (16 * (i.a / 2))) & 32'hFFFF;
            LWL:     v = r << (8 * (3 - i.a));
            LWR:     v = r >> sh;
            default: v = r;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_we(input ins_t i);
        logic [3:0] w;
        w = i.we;
        if (i.req && i.op == LWL) begin
            case (i.a)
                2'd0: w = 4'b1000;
                2'd1: w = 4'b1100;
                2'd2: w = 4'b1110;
                default: w = 4'b1111;
            endcase
        end else if (i.req && i.op == LWR) begin
            case (i.a)
                2'd0: w = 4'b1111;
                2'd1: w = 4'b0111;
                2'd2: w = 4'b0011;
                default: w = 4'b0001;
            endcase
        end
        return w;
    endfunction

    logic        m_valid = 1'b0;
    ins_t        m_ins   = '0;
    logic        m_have  = 1'b0;   // response for the held load already received
    logic [31:0] m_data  = '0;
    int          m_drops = 0;      // responses still owed to discarded loads

    initial forever begin
        logic        fl, resp, ready, xv, xa, xlp;
        logic [31:0] r, res;
        logic [3:0]  we;
        @(negedge clk);
        if (!resetn) begin
            m_valid = 1'b0;
            m_have  = 1'b0;
            m_drops = 0;
            check("m_rst_ws_valid", {95'd0, ms_to_ws_valid}, 96'd0);
            check("m_rst_allowin", {95'd0, ms_allowin}, 96'd1);
            check("m_rst_fwd_lp", {91'd0, ms_to_ds_bus[41:37]}, 96'd0);
            check("m_rst_ex_eret", {95'd0, ms_ex_eret}, 96'd0);
        end else begin
            fl    = ws_ex | ws_eret;
            resp  = data_sram_data_ok && (m_drops == 0);
            ready = !m_ins.req || m_have || resp;
            xv    = m_valid && ready && !fl;
            xa    = !m_valid || (ready && ws_allowin);
            xlp   = m_valid && m_ins.req && !m_have && !resp;
            r     = m_have ? m_data : data_sram_rdata;
            res   = m_result(m_ins, r);
            we    = m_we(m_ins);
            check("m_ws_valid", {95'd0, ms_to_ws_valid}, {95'd0, xv});
            check("m_allowin", {95'd0, ms_allowin}, {95'd0, xa});
            check("m_load_pending", {95'd0, ms_to_ds_bus[37]}, {95'd0, xlp});
            check("m_fwd_we", {92'd0, ms_to_ds_bus[41:38]}, {92'd0, m_valid ? we : 4'd0});
            check("m_ex_eret", {95'd0, ms_ex_eret},
                  {95'd0, m_valid && (m_ins.ex || m_ins.root[10])});
            if (m_valid)
                check("m_ds_dest", {91'd0, ms_to_ds_bus[36:32]}, {91'd0, m_ins.dest});
            if (m_valid && !xlp)
                check("m_ds_result", {64'd0, ms_to_ds_bus[31:0]}, {64'd0, res});
            if (xv)
                check("m_ws_bus", {5'd0, ms_to_ws_bus},
                      {5'd0, m_ins.root, m_ins.bd, m_ins.ex, m_ins.excode,
                       we, m_ins.dest, res, m_ins.pc});
            if (data_sram_data_ok && m_drops > 0) m_drops--;
            if (fl && xlp) m_drops++;
            if (m_valid && m_ins.req && !m_have && resp && !(xv && ws_allowin)) begin
                m_have = 1'b1;
                m_data = data_sram_rdata;
            end
            if (fl) begin
                m_valid = 1'b0;
                m_have  = 1'b0;
            end else if (xa) begin
                m_valid = es_to_ms_valid;
                m_ins   = es_to_ms_bus;
                m_have  = 1'b0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h5A5A_5A5A;
        ws_ex             = 1'b0;
        ws_eret           = 1'b0;
        ws_allowin        = 1'b1;
    endtask

    task automatic issue(input ins_t i);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = i;
    endtask

    initial begin
        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h5A5A_5A5A;
        ws_ex             = 1'b0;
        ws_eret           = 1'b0;
        ws_allowin        = 1'b1;
        #2;
        check("rst_ws_valid", {95'd0, ms_to_ws_valid}, 96'd0);
        check("rst_allowin", {95'd0, ms_allowin}, 96'd1);
        check("rst_fwd_we", {92'd0, ms_to_ds_bus[41:38]}, 96'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // ALU op passes in one cycle
        step(); issue(mk(NOP, 1'b0, 2'd0, 4'hF, 5'd5, 32'h1234_5678, 1'b0, 11'd0));
        step(); #1;
        check("alu_valid", {95'd0, ms_to_ws_valid}, 96'd1);
        check("alu_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h1234_5678);
        check("alu_we", {92'd0, ms_to_ws_bus[72:69]}, 96'hF);
        check("alu_fwd_we", {92'd0, ms_to_ds_bus[41:38]}, 96'hF);
        step(); #1;
        check("alu_gone", {95'd0, ms_to_ws_valid}, 96'd0);

        // lb a=3, response after 3 waiting cycles
        step(); issue(mk(LB, 1'b1, 2'd3, 4'hF, 5'd6, 32'h1000_0003, 1'b0, 11'd0));
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            check("lb_pending", {95'd0, ms_to_ds_bus[37]}, 96'd1);
        end
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF00; #1;
        check("lb_valid", {95'd0, ms_to_ws_valid}, 96'd1);
        check("lb_result", {64'd0, ms_to_ws_bus[63:32]}, 96'hFFFF_FF80);

        // lwl a=1 then lwr a=2 back to back
        step(); issue(mk(LWL, 1'b1, 2'd1, 4'hF, 5'd7, 32'h1000_0001, 1'b0, 11'd0));
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD;
        issue(mk(LWR, 1'b1, 2'd2, 4'hF, 5'd8, 32'h1000_0002, 1'b0, 11'd0)); #1;
        check("lwl_result", {64'd0, ms_to_ws_bus[63:32]}, 96'hCCDD_0000);
        check("lwl_we", {92'd0, ms_to_ws_bus[72:69]}, 96'b1100);
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD; #1;
        check("lwr_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h0000_AABB);
        check("lwr_we", {92'd0, ms_to_ws_bus[72:69]}, 96'b0011);

        // flushed lw; its late response must be dropped
        step(); issue(mk(LW, 1'b1, 2'd0, 4'hF, 5'd9, 32'h1000_0000, 1'b0, 11'd0));
        step(); ws_ex = 1'b1; #1;
        check("flush_no_valid", {95'd0, ms_to_ws_valid}, 96'd0);
        step(); issue(mk(LHU, 1'b1, 2'd2, 4'hF, 5'd10, 32'h1000_0002, 1'b0, 11'd0));
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; #1;
        check("drop_ignored", {95'd0, ms_to_ws_valid}, 96'd0);
        check("drop_pending", {95'd0, ms_to_ds_bus[37]}, 96'd1);
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678; #1;
        check("lhu_valid", {95'd0, ms_to_ws_valid}, 96'd1);
        check("lhu_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h0000_1234);

        // WS stalls for two cycles; response is buffered
        step(); issue(mk(LW, 1'b1, 2'd0, 4'hF, 5'd11, 32'h1000_0010, 1'b0, 11'd0));
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D; ws_allowin = 1'b0; #1;
        check("buf_valid0", {95'd0, ms_to_ws_valid}, 96'd1);
        check("buf_allowin0", {95'd0, ms_allowin}, 96'd0);
        step(); ws_allowin = 1'b0; #1;
        check("buf_valid1", {95'd0, ms_to_ws_valid}, 96'd1);
        check("buf_result1", {64'd0, ms_to_ws_bus[63:32]}, 96'hCAFE_F00D);
        step(); #1;
        check("buf_result2", {64'd0, ms_to_ws_bus[63:32]}, 96'hCAFE_F00D);
        step(); #1;
        check("buf_gone", {95'd0, ms_to_ws_valid}, 96'd0);

        // flush and data_ok together: consumed, nothing dropped afterwards
        step(); issue(mk(LW, 1'b1, 2'd0, 4'hF, 5'd12, 32'h1000_0020, 1'b0, 11'd0));
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111; ws_eret = 1'b1; #1;
        check("flush_ok_valid", {95'd0, ms_to_ws_valid}, 96'd0);
        step(); issue(mk(LBU, 1'b1, 2'd1, 4'hF, 5'd13, 32'h1000_0021, 1'b0, 11'd0));
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_AB00; #1;
        check("lbu_valid", {95'd0, ms_to_ws_valid}, 96'd1);
        check("lbu_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h0000_00AB);

        // excepting instruction and eret pass straight through
        step(); issue(mk(LW, 1'b0, 2'd1, 4'hF, 5'd14, 32'hBADA_DD01, 1'b1, 11'd0));
        step(); issue(mk(NOP, 1'b0, 2'd0, 4'h0, 5'd0, 32'h0, 1'b0, 11'h400)); #1;
        check("ex_valid", {95'd0, ms_to_ws_valid}, 96'd1);
        check("ex_eret_ex", {95'd0, ms_ex_eret}, 96'd1);
        check("ex_bit", {95'd0, ms_to_ws_bus[78]}, 96'd1);
        step(); #1;
        check("ex_eret_eret", {95'd0, ms_ex_eret}, 96'd1);

        // drop-clearing response coincides with capture of a new load
        step(); issue(mk(LW, 1'b1, 2'd0, 4'hF, 5'd15, 32'h1000_0030, 1'b0, 11'd0));
        step(); ws_ex = 1'b1;
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        issue(mk(LB, 1'b1, 2'd0, 4'hF, 5'd16, 32'h1000_0030, 1'b0, 11'd0));
        step(); #1;
        check("new_waits", {95'd0, ms_to_ds_bus[37]}, 96'd1);
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_00FE; #1;
        check("lb2_result", {64'd0, ms_to_ws_bus[63:32]}, 96'hFFFF_FFFE);

        // reset asserted while a load waits
        step(); issue(mk(LW, 1'b1, 2'd0, 4'hF, 5'd17, 32'h1000_0040, 1'b0, 11'd0));
        step(); #1;
        check("rw_pending", {95'd0, ms_to_ds_bus[37]}, 96'd1);
        #1 resetn = 1'b0;
        #1;
        check("rw_ws_valid", {95'd0, ms_to_ws_valid}, 96'd0);
        check("rw_allowin", {95'd0, ms_allowin}, 96'd1);
        check("rw_fwd_lp", {91'd0, ms_to_ds_bus[41:37]}, 96'd0);
        check("rw_ex_eret", {95'd0, ms_ex_eret}, 96'd0);
        step();
        step(); resetn = 1'b1; #1;
        check("rw_release_allowin", {95'd0, ms_allowin}, 96'd1);
        step(); issue(mk(LW, 1'b1, 2'd0, 4'hF, 5'd18, 32'h1000_0050, 1'b0, 11'd0));
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h600D_F00D; #1;
        check("post_rst_valid", {95'd0, ms_to_ws_valid}, 96'd1);
        check("post_rst_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h600D_F00D);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
